// File: rtl/id_qbuf.sv
// Decode-to-dispatch queue buffer: a small circular FIFO holding decoded bundles,
// with one-cycle latency, flush, global enable and an almost-full indication.
module id_qbuf #(
  parameter int PAYLOAD_W = 128,
  parameter int DEPTH     = 4,
  parameter int AFULL_LVL = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cpu_en,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [PAYLOAD_W-1:0]       in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [PAYLOAD_W-1:0]       out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       afull
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(AFULL_LVL);

  logic [PAYLOAD_W-1:0] mem_q [DEPTH];
  logic [PAYLOAD_W-1:0] mem_d [DEPTH];
  logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 enq, deq;

  // Full blocks new entries even when the head is leaving this cycle, so
  // in_ready never depends on out_ready.
  assign in_ready  = cpu_en && !flush && (count_q < DEPTH_C);
  assign out_valid = cpu_en && (count_q != '0);
  assign out_data  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count     = count_q;
  assign afull     = (count_q >= AFULL_C);

  assign enq = in_valid && in_ready;
  assign deq = out_valid && out_ready && !flush;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (cpu_en && flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) begin
        mem_d[wr_ptr_q] = in_data;
        wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      end
      if (enq && !deq) begin
        count_d = count_q + CNT_W'(1);
      end else if (deq && !enq) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: doc/id_qbuf.md
ID_QBUF -- requirements
Module: id_qbuf

Interface
REQ-001 The module SHALL have parameter PAYLOAD_W, default 128, meaning the width of the decode bundle carried per entry (pc, rs addrs, ops, imm, rob tag, rat info, operand values packed by the instantiating stage).
REQ-002 The module SHALL have parameter DEPTH, default 4, meaning the number of entries; legal values are powers of two, 2 to 16.
REQ-003 The module SHALL have parameter AFULL_LVL, default DEPTH-1, meaning the occupancy at which afull asserts.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 cpu_en  input  1  global enable; low freezes all state.
REQ-007 flush  input  1  discards all entries, including any same-cycle enqueue.
REQ-008 in_valid  input  1  upstream (decode) offers in_data.
REQ-009 in_data  input  PAYLOAD_W  bundle from decode/RAT.
REQ-010 in_ready  output  1  buffer can accept an entry this cycle.
REQ-011 out_valid  output  1  head entry is present on out_data.
REQ-012 out_data  output  PAYLOAD_W  head entry bundle.
REQ-013 out_ready  input  1  downstream (dispatch) takes the head entry; low acts as the stall.
REQ-014 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-015 afull  output  1  count >= AFULL_LVL.

Function
REQ-016 Storage SHALL be a circular buffer: wr_ptr and rd_ptr of $clog2(DEPTH) bits, wrapping from DEPTH-1 to 0 with no extra logic.
REQ-017 in_ready SHALL equal cpu_en && !flush && (count < DEPTH); it SHALL NOT depend combinationally on out_ready.
REQ-018 out_valid SHALL equal cpu_en && (count != 0).
REQ-019 out_data SHALL equal the entry at rd_ptr when count != 0, and all-zero when count == 0.
REQ-020 Enqueue SHALL occur on a rising edge when in_valid && in_ready: entry[wr_ptr] <= in_data, wr_ptr increments.
REQ-021 Dequeue SHALL occur on a rising edge when out_valid && out_ready && !flush: rd_ptr increments.
REQ-022 count SHALL increment on enqueue-only, decrement on dequeue-only, and hold when both or neither occur.
REQ-023 Latency SHALL be one cycle: an entry enqueued at edge N is visible on out_data/out_valid after edge N; no combinational in-to-out bypass.
REQ-024 Order SHALL be strict FIFO; each accepted entry SHALL be output exactly once unless flushed.
REQ-025 Full (count == DEPTH): in_ready = 0 even if out_ready = 1 that cycle; the freed slot becomes available the following cycle.
REQ-026 Empty (count == 0): a dequeue request SHALL have no effect; rd_ptr and count unchanged.
REQ-027 Simultaneous enqueue and dequeue at 0 < count < DEPTH SHALL advance both pointers and keep count.
REQ-028 When cpu_en && flush at an edge, wr_ptr, rd_ptr and count SHALL become 0; entry contents need not be cleared; flush has priority over enqueue and dequeue.
REQ-029 When cpu_en == 0, pointers, count and entries SHALL hold, flush included; in_ready and out_valid read 0.
REQ-030 afull SHALL be derived from count only, combinationally.

Reset
REQ-031 On rst_n low, asynchronously: wr_ptr = 0, rd_ptr = 0, count = 0, all entries = 0.
REQ-032 During and after reset: out_valid = 0, out_data = 0, count = 0, afull = 0 (for AFULL_LVL >= 1), in_ready = cpu_en.
REQ-033 Reset asserted mid-operation SHALL discard all entries immediately, with no partial update at the coincident edge.

Verification
REQ-034 DEPTH=4, out_ready=0, push A,B,C,D -> count 1,2,3,4; afull from count 3; in_ready=0 after 4th push; out_data=A.
REQ-035 Full, out_ready=1 and in_valid=1 with E -> only A pops, count 3; next cycle E accepted, count 4; drain order B,C,D,E.
REQ-036 count=2, push and pop every cycle for 10 cycles -> count stays 2; pointers wrap; outputs in exact push order.
REQ-037 count=3, flush with in_valid=1, out_ready=1 -> next cycle count=0, out_valid=0, out_data=0; the offered entry is not stored.
REQ-038 cpu_en=0 for 3 cycles with in_valid=1, out_ready=1, flush=1 -> in_ready=0, out_valid=0, count unchanged; after cpu_en returns, original head visible.
REQ-039 rst_n pulsed low between edges with count=2 -> count=0, out_valid=0 immediately; first push after release appears after one edge.
